// File: rtl/alu_dot_sequencer.sv
`default_nettype none
// ---------------------------------------------------------------------------
// alu_dot_sequencer: runs the shared ALU through multiply/accumulate steps to
// form the dot product of two operand-memory vectors.
// Revision: 1.0
// ---------------------------------------------------------------------------
module alu_dot_sequencer #(
  parameter int         DW      = 16,
  parameter int         AW      = 4,
  parameter logic [2:0] OP_IDLE = 3'd0,
  parameter logic [2:0] OP_ADD  = 3'd1,
  parameter logic [2:0] OP_MUL  = 3'd2
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [AW:0]   len,
  output logic          busy,
  output logic          done,
  output logic [DW-1:0] result,
  output logic          result_zero,
  output logic [AW-1:0] a_addr,
  output logic [AW-1:0] b_addr,
  input  logic [DW-1:0] a_data,
  input  logic [DW-1:0] b_data,
  output logic [DW-1:0] alu_in1,
  output logic [DW-1:0] alu_in2,
  output logic [2:0]    alu_control,
  input  logic [DW-1:0] alu_out,
  input  logic          alu_zflag
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_MUL   = 3'd2,
    S_ADD   = 3'd3,
    S_WB    = 3'd4,
    S_DONE  = 3'd5
  } state_t;

  state_t        state;
  logic [AW:0]   len_q;
  logic [AW-1:0] idx;
  logic [DW-1:0] acc;
  logic          last_elem;

  assign last_elem = ({1'b0, idx} == (len_q - 1'b1));

  // Memory data and the ALU product are only valid during MUL/ADD themselves,
  // so the operand mux has to be combinational on the state.
  always_comb begin
    alu_in1 = '0;
    alu_in2 = '0;
    case (state)
      S_MUL: begin
        alu_in1 = a_data;
        alu_in2 = b_data;
      end
      S_ADD: begin
        alu_in1 = acc;
        alu_in2 = alu_out;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      len_q       <= '0;
      idx         <= '0;
      acc         <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      result      <= '0;
      result_zero <= 1'b0;
      a_addr      <= '0;
      b_addr      <= '0;
      alu_control <= OP_IDLE;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            len_q <= len;
            idx   <= '0;
            acc   <= '0;
            busy  <= 1'b1;
            if (len == '0) begin
              state       <= S_DONE;
              done        <= 1'b1;
              result      <= '0;
              result_zero <= 1'b1;
            end else begin
              state  <= S_FETCH;
              a_addr <= '0;
              b_addr <= '0;
            end
          end
        end
        S_FETCH: begin
          state       <= S_MUL;
          alu_control <= OP_MUL;
        end
        S_MUL: begin
          state       <= S_ADD;
          alu_control <= OP_ADD;
        end
        S_ADD: begin
          state       <= S_WB;
          alu_control <= OP_IDLE;
        end
        S_WB: begin
          acc <= alu_out;
          if (last_elem) begin
            // Publish the freshly accumulated sum on the same edge acc takes it.
            state       <= S_DONE;
            done        <= 1'b1;
            result      <= alu_out;
            result_zero <= alu_zflag;
          end else begin
            state  <= S_FETCH;
            idx    <= idx + 1'b1;
            a_addr <= idx + 1'b1;
            b_addr <= idx + 1'b1;
          end
        end
        S_DONE: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state       <= S_IDLE;
          busy        <= 1'b0;
          alu_control <= OP_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_alu_dot_sequencer.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_alu_dot_sequencer: table-driven dot-product vectors plus hand-written
// start-hold and mid-run reset sequences. Revision: 1.0
// ---------------------------------------------------------------------------
module tb_alu_dot_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [4:0]  len;
  logic        busy, done, result_zero;
  logic [15:0] result;
  logic [3:0]  a_addr, b_addr;
  logic [15:0] a_data, b_data;
  logic [15:0] alu_in1, alu_in2, alu_out;
  logic [2:0]  alu_control;
  logic        alu_zflag;

  int checks   = 0;
  int failures = 0;

  logic [15:0] mem_a [16];
  logic [15:0] mem_b [16];

  bit         saw_op;
  logic [3:0] mul_addrs [$];

  always #5 clk = ~clk;

  alu_dot_sequencer dut (
    .clk(clk), .rst_n(rst_n), .start(start), .len(len),
    .busy(busy), .done(done), .result(result), .result_zero(result_zero),
    .a_addr(a_addr), .b_addr(b_addr), .a_data(a_data), .b_data(b_data),
    .alu_in1(alu_in1), .alu_in2(alu_in2), .alu_control(alu_control),
    .alu_out(alu_out), .alu_zflag(alu_zflag)
  );

  // Synchronous-read operand memories
  always @(posedge clk) begin
    a_data <= mem_a[a_addr];
    b_data <= mem_b[b_addr];
  end

  // Registered ALU model, results modulo 2^16
  always @(posedge clk) begin
    case (alu_control)
      3'd1: begin
        alu_out   <= 16'(alu_in1 + alu_in2);
        alu_zflag <= (16'(alu_in1 + alu_in2) == 16'd0);
      end
      3'd2: begin
        alu_out   <= 16'(alu_in1 * alu_in2);
        alu_zflag <= (16'(alu_in1 * alu_in2) == 16'd0);
      end
      default: ;
    endcase
  end

  always @(negedge clk) begin
    if (alu_control != 3'd0) saw_op = 1'b1;
    if (alu_control == 3'd2) begin
      mul_addrs.push_back(a_addr);
      if (a_addr != b_addr) mul_addrs.push_back(4'hF);
    end
  end

  typedef struct packed {
    logic [4:0]        len;
    logic [15:0][15:0] a;
    logic [15:0][15:0] b;
    logic [15:0]       exp_result;
    logic              exp_zero;
  } vec_t;

  vec_t tbl [7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  task automatic run_check(input string name, input logic [4:0] l,
                           input logic [15:0] exp_r, input logic exp_z);
    int cyc;
    int done_cyc;
    bit busy_ok;
    @(posedge clk); #1;
    start = 1'b1;
    len   = l;
    @(posedge clk); #1;
    start    = 1'b0;
    cyc      = 1;
    done_cyc = -1;
    busy_ok  = 1'b1;
    while (done_cyc < 0 && cyc <= 100) begin
      if (!busy) busy_ok = 1'b0;
      if (done) done_cyc = cyc;
      else begin
        @(posedge clk); #1;
        cyc++;
      end
    end
    chk({name, " done_cycle"}, done_cyc, 4 * int'(l) + 1);
    chk({name, " result"}, {16'd0, result}, {16'd0, exp_r});
    chk({name, " result_zero"}, {31'd0, result_zero}, {31'd0, exp_z});
    chk({name, " busy_window"}, {31'd0, busy_ok}, 32'd1);
    @(posedge clk); #1;
    chk({name, " done_then_idle"}, {30'd0, done, busy}, 32'd0);
  endtask

  initial begin
    // Vector table, hand-computed sums
    for (int t = 0; t < 7; t++) tbl[t] = '0;
    tbl[0].len = 5'd3;
    tbl[0].a[0] = 16'd1; tbl[0].a[1] = 16'd2; tbl[0].a[2] = 16'd3;
    tbl[0].b[0] = 16'd4; tbl[0].b[1] = 16'd5; tbl[0].b[2] = 16'd6;
    tbl[0].exp_result = 16'd32; tbl[0].exp_zero = 1'b0;
    tbl[1].len = 5'd0;
    tbl[1].a[0] = 16'd9; tbl[1].b[0] = 16'd9;
    tbl[1].exp_result = 16'd0; tbl[1].exp_zero = 1'b1;
    tbl[2].len = 5'd2;
    tbl[2].a[0] = 16'd256; tbl[2].a[1] = 16'd256;
    tbl[2].b[0] = 16'd256; tbl[2].b[1] = 16'd256;
    tbl[2].exp_result = 16'd0; tbl[2].exp_zero = 1'b1;
    tbl[3].len = 5'd1;
    tbl[3].a[0] = 16'hFFFF; tbl[3].b[0] = 16'd1;
    tbl[3].exp_result = 16'hFFFF; tbl[3].exp_zero = 1'b0;
    tbl[4].len = 5'd2;
    tbl[4].a[0] = 16'd1; tbl[4].a[1] = 16'hFFFF;
    tbl[4].b[0] = 16'd1; tbl[4].b[1] = 16'd1;
    tbl[4].exp_result = 16'd0; tbl[4].exp_zero = 1'b1;
    tbl[5].len = 5'd16;
    for (int k = 0; k < 16; k++) begin
      tbl[5].a[k] = 16'(k);
      tbl[5].b[k] = 16'd1;
    end
    tbl[5].exp_result = 16'd120; tbl[5].exp_zero = 1'b0;
    tbl[6].len = 5'd4;
    tbl[6].a[0] = 16'd3; tbl[6].a[1] = 16'd5; tbl[6].a[2] = 16'd7; tbl[6].a[3] = 16'd9;
    tbl[6].b[0] = 16'd2; tbl[6].b[1] = 16'd4; tbl[6].b[2] = 16'd6; tbl[6].b[3] = 16'd8;
    tbl[6].exp_result = 16'd140; tbl[6].exp_zero = 1'b0;

    for (int k = 0; k < 16; k++) begin
      mem_a[k] = '0;
      mem_b[k] = '0;
    end
    rst_n = 1'b0;
    start = 1'b0;
    len   = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset busy_done", {30'd0, busy, done}, 32'd0);
    chk("reset result", {15'd0, result, result_zero}, 32'd0);
    chk("reset alu", {13'd0, alu_control, alu_in1}, 32'd0);
    chk("reset addr", {24'd0, a_addr, b_addr}, 32'd0);
    rst_n = 1'b1;

    for (int t = 0; t < 7; t++) begin
      for (int k = 0; k < 16; k++) begin
        mem_a[k] = tbl[t].a[k];
        mem_b[k] = tbl[t].b[k];
      end
      @(negedge clk);
      saw_op = 1'b0;
      mul_addrs.delete();
      run_check($sformatf("vec%0d", t), tbl[t].len, tbl[t].exp_result, tbl[t].exp_zero);
      if (tbl[t].len == 5'd0) chk("len0 no_alu_op", {31'd0, saw_op}, 32'd0);
      if (tbl[t].len == 5'd16) begin
        bit sweep_ok;
        sweep_ok = (mul_addrs.size() == 16);
        for (int k = 0; k < mul_addrs.size() && k < 16; k++)
          if (mul_addrs[k] != 4'(k)) sweep_ok = 1'b0;
        chk("len16 addr_sweep", {31'd0, sweep_ok}, 32'd1);
      end
    end

    // start held high: second request accepted only once back in IDLE
    begin
      int done_cnt;
      int d1;
      int d2;
      mem_a[0] = 16'd2; mem_a[1] = 16'd3;
      mem_b[0] = 16'd4; mem_b[1] = 16'd5;
      done_cnt = 0; d1 = -1; d2 = -1;
      @(posedge clk); #1;
      start = 1'b1;
      len   = 5'd2;
      for (int c = 1; c <= 25; c++) begin
        @(posedge clk); #1;
        if (c == 3)  len = 5'd5;
        if (c == 9)  len = 5'd2;
        if (c == 11) start = 1'b0;
        if (done) begin
          done_cnt++;
          if (d1 < 0) d1 = c; else d2 = c;
        end
      end
      chk("hold done_count", done_cnt, 32'd2);
      chk("hold first_done", d1, 32'd9);
      chk("hold second_done", d2, 32'd19);
      chk("hold result", {16'd0, result}, 32'd23);
    end

    // Reset in cycle 6 of a len=4 run, then a fresh len=1 run
    begin
      bit no_done;
      for (int k = 0; k < 4; k++) begin
        mem_a[k] = tbl[6].a[k];
        mem_b[k] = tbl[6].b[k];
      end
      @(posedge clk); #1;
      start = 1'b1;
      len   = 5'd4;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (5) @(posedge clk);
      #1;
      chk("pre_reset in_mul", {29'd0, alu_control}, 32'd2);
      rst_n = 1'b0;
      #1;
      chk("midrst busy_done", {30'd0, busy, done}, 32'd0);
      chk("midrst result", {15'd0, result, result_zero}, 32'd0);
      chk("midrst alu", {13'd0, alu_control, alu_in1}, 32'd0);
      chk("midrst alu_in2", {16'd0, alu_in2}, 32'd0);
      chk("midrst addr", {24'd0, a_addr, b_addr}, 32'd0);
      no_done = 1'b1;
      for (int c = 0; c < 3; c++) begin
        @(posedge clk); #1;
        if (done || busy) no_done = 1'b0;
      end
      rst_n = 1'b1;
      for (int c = 0; c < 20; c++) begin
        @(posedge clk); #1;
        if (done || busy) no_done = 1'b0;
      end
      chk("midrst no_partial", {31'd0, no_done}, 32'd1);
      mem_a[0] = 16'd7;
      mem_b[0] = 16'd3;
      run_check("after_reset", 5'd1, 16'd21, 1'b0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
